id_stage_control: RTL
=====================

Name: id_stage_control

Overview:
- Registered RV32IM decode/control stage. Sits between the IF/ID and ID/EX pipeline registers.
- Decodes INSTRUCTION into the standard control bundle and registers it with 1-cycle latency.
- Adds load-use hazard bubbling, multi-cycle MUL/DIV issue stalls, flush squashing and illegal-opcode flagging.
- M-extension latency and enable are parametrised.

Parameters:
ENABLE_M, 1, 1 = decode M-extension ops; 0 = opcode 0110011 with funct7 0000001 is illegal
MUL_LATENCY, 2, EX cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0); ≥1
DIV_LATENCY, 8, EX cycles for DIV/DIVU/REM/REMU (funct3[2]=1); ≥1
CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max latency

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
INSTRUCTION  in  32  instruction held in IF/ID
IF_VALID  in  1  INSTRUCTION is valid
FLUSH  in  1  taken branch/jump resolved in EX; squash ID
EX_MEM_READ  in  1  instruction now in EX is a load
EX_RD  in  5  destination register of instruction in EX
STALL_IF  out  1  combinational; hold PC and IF/ID this cycle
CTRL_VALID  out  1  registered bundle is a real instruction
ALU_SIGNAL  out  5  registered ALU select
REG_FILE_WRITE  out  1  registered
MAIN_MEM_WRITE  out  3  {store, funct3[1:0]}
MAIN_MEM_READ  out  4  {load, funct3}
BRANCH_CONTROL  out  4  {jump/branch, type}
IMMEDIATE_SELECT  out  4  {unsigned, format}
OPERAND_1_SELECT  out  1  1 = PC
OPERAND_2_SELECT  out  1  1 = immediate
REG_WRITE_SELECT  out  2  writeback source
RD_OUT  out  5  INSTRUCTION[11:7], registered
ILLEGAL  out  1  registered unknown-opcode flag

Behaviour:
- Reset (RESET=0, async): all registered outputs 0; FSM to IDLE; counter 0.
- Decode (combinational, then registered on the next rising edge):
  - ALU_SIGNAL[2:0] = funct3, or 000 for AUIPC/JAL/JALR/load/store.
  - ALU_SIGNAL[3] = M-op or LUI.
  - ALU_SIGNAL[4] = SUB/SRA/SRAI or LUI.
  - REG_FILE_WRITE = not (store or branch).
  - BRANCH_CONTROL = {JAL|JALR|branch, (JAL|JALR)?010:funct3}.
  - IMMEDIATE_SELECT[2:0] = U 000, J 001, I 010, B 011, S 100, shift-imm 101.
  - IMMEDIATE_SELECT[3] = LBU/LHU/SLTIU.
  - OPERAND_1_SELECT = AUIPC|JAL|JALR.
  - OPERAND_2_SELECT = any opcode except 0110011.
  - REG_WRITE_SELECT = {AUIPC, not load}.
- Bubble: CTRL_VALID=0 and REG_FILE_WRITE=0, MAIN_MEM_WRITE[2]=0, MAIN_MEM_READ[3]=0, BRANCH_CONTROL[3]=0, ILLEGAL=0. All other fields are don't-care and are driven 0.
- Load-use hazard: EX_MEM_READ & EX_RD≠0 & EX_RD matches a used source register (rs1 for all but LUI/AUIPC/JAL; rs2 for R/S/B). On hazard: STALL_IF=1, bubble issued, one cycle.
- FSM IDLE/BUSY:
  - In IDLE, when a valid, non-stalled, non-flushed M-op issues: load counter with LAT-1. If LAT=1, remain IDLE.
  - BUSY: STALL_IF=1, bubbles issued, counter decrements each cycle; at 0, return to IDLE. The held instruction issues on the following cycle.
- Illegal opcode (or M-op with ENABLE_M=0): ILLEGAL=1, CTRL_VALID=1, all write/read/branch enables 0.
- Priority, highest first: RESET > FLUSH > BUSY > load-use > normal issue.
  - FLUSH: bubble, STALL_IF=0; BUSY counting continues unaffected.
  - IF_VALID=0: bubble, STALL_IF=0.
- Latency: valid instruction at edge N appears on outputs after edge N+1.

Test Plan:
- Reset mid-BUSY (DIV issued, assert RESET low after 3 cycles) -> outputs 0 immediately, STALL_IF=0, IDLE; next DIV restarts a full 7-cycle stall.
- ADD x3,x1,x2 (0x002081B3), IF_VALID=1 -> next cycle CTRL_VALID=1, ALU_SIGNAL=00000, REG_FILE_WRITE=1, OPERAND_2_SELECT=0, RD_OUT=3.
- EX_MEM_READ=1, EX_RD=1, ID holds ADD x3,x1,x2 -> STALL_IF=1 for 1 cycle, one bubble, then ADD issues. With EX_RD=0 -> no stall.
- DIV (funct7=0000001, funct3=100), DIV_LATENCY=8 -> DIV issues, then STALL_IF=1 and bubbles for 7 cycles, then next instruction issues. MUL with MUL_LATENCY=2 -> 1 stall cycle.
- FLUSH=1 together with a load-use hazard -> bubble, STALL_IF=0. FLUSH during BUSY -> counter still reaches 0 on schedule.
- Opcode 0000000 -> ILLEGAL=1, CTRL_VALID=1, REG_FILE_WRITE=0. ENABLE_M=0 with MUL -> ILLEGAL=1, no stall.

Source files
------------

// File: rtl/id_stage_control.sv
// RV32IM decode/control stage: registers the control bundle one cycle after IF/ID, inserting bubbles for
// flush, load-use hazards and multi-cycle MUL/DIV; STALL_IF is combinational and holds PC and IF/ID.
module id_stage_control #(
  parameter bit ENABLE_M    = 1'b1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IF_VALID,
  input  logic        FLUSH,
  input  logic        EX_MEM_READ,
  input  logic [4:0]  EX_RD,
  output logic        STALL_IF,
  output logic        CTRL_VALID,
  output logic [4:0]  ALU_SIGNAL,
  output logic        REG_FILE_WRITE,
  output logic [2:0]  MAIN_MEM_WRITE,
  output logic [3:0]  MAIN_MEM_READ,
  output logic [3:0]  BRANCH_CONTROL,
  output logic [3:0]  IMMEDIATE_SELECT,
  output logic        OPERAND_1_SELECT,
  output logic        OPERAND_2_SELECT,
  output logic [1:0]  REG_WRITE_SELECT,
  output logic [4:0]  RD_OUT,
  output logic        ILLEGAL
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_dec;

  logic [6:0] w_opcode, w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op;
  logic w_mop, w_legal, w_use_rs1, w_use_rs2, w_hazard, w_busy, w_issue, w_m_issue;

  logic       w_n_vld, w_n_ill, w_n_rfw, w_n_op1, w_n_op2;
  logic [4:0] w_n_alu, w_n_rd;
  logic [2:0] w_n_mw;
  logic [3:0] w_n_mr, w_n_bc, w_n_imm;
  logic [1:0] w_n_rws;

  assign w_opcode = INSTRUCTION[6:0];
  assign w_rd     = INSTRUCTION[11:7];
  assign w_f3     = INSTRUCTION[14:12];
  assign w_rs1    = INSTRUCTION[19:15];
  assign w_rs2    = INSTRUCTION[24:20];
  assign w_f7     = INSTRUCTION[31:25];

  assign w_lui   = (w_opcode == OP_LUI);
  assign w_auipc = (w_opcode == OP_AUIPC);
  assign w_jal   = (w_opcode == OP_JAL);
  assign w_jalr  = (w_opcode == OP_JALR);
  assign w_br    = (w_opcode == OP_BRANCH);
  assign w_ld    = (w_opcode == OP_LOAD);
  assign w_st    = (w_opcode == OP_STORE);
  assign w_opi   = (w_opcode == OP_IMM);
  assign w_op    = (w_opcode == OP_REG);
  assign w_mop   = w_op && (w_f7 == 7'b0000001);

  assign w_legal = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi
                 | (w_op & (ENABLE_M | ~w_mop));

  // Only a genuinely read source register can create a load-use dependency.
  assign w_use_rs1 = ~(w_lui | w_auipc | w_jal);
  assign w_use_rs2 = w_op | w_st | w_br;
  assign w_hazard  = IF_VALID & EX_MEM_READ & (EX_RD != 5'd0)
                   & ((w_use_rs1 & (EX_RD == w_rs1)) | (w_use_rs2 & (EX_RD == w_rs2)));

  assign w_busy    = (r_state == S_BUSY);
  assign STALL_IF  = ~FLUSH & (w_busy | w_hazard);
  assign w_issue   = IF_VALID & ~FLUSH & ~w_busy & ~w_hazard;
  assign w_m_issue = w_issue & w_mop & ENABLE_M;
  assign w_cnt_dec = r_cnt - 1'b1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter keeps running under FLUSH so the EX unit's schedule is never disturbed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_m_issue) begin
          w_cnt_nxt = w_f3[2] ? DIV_CNT : MUL_CNT;
          if (w_cnt_nxt != '0) w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == '0) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_n_vld = 1'b0;
    w_n_ill = 1'b0;
    w_n_rfw = 1'b0;
    w_n_op1 = 1'b0;
    w_n_op2 = 1'b0;
    w_n_alu = '0;
    w_n_rd  = '0;
    w_n_mw  = '0;
    w_n_mr  = '0;
    w_n_bc  = '0;
    w_n_imm = '0;
    w_n_rws = '0;
    if (w_issue) begin
      w_n_vld = 1'b1;
      w_n_rd  = w_rd;
      if (!w_legal) begin
        w_n_ill = 1'b1;
      end else begin
        w_n_alu[2:0] = (w_auipc | w_jal | w_jalr | w_ld | w_st) ? 3'b000 : w_f3;
        w_n_alu[3]   = w_mop | w_lui;
        w_n_alu[4]   = w_lui
                     | (w_op & ~w_mop & w_f7[5] & ((w_f3 == 3'b000) | (w_f3 == 3'b101)))
                     | (w_opi & w_f7[5] & (w_f3 == 3'b101));
        w_n_rfw = ~(w_st | w_br);
        w_n_mw  = {w_st, w_f3[1:0]};
        w_n_mr  = {w_ld, w_f3};
        w_n_bc  = {w_jal | w_jalr | w_br, (w_jal | w_jalr) ? 3'b010 : w_f3};
        if (w_lui | w_auipc)                 w_n_imm[2:0] = 3'b000;
        else if (w_jal)                      w_n_imm[2:0] = 3'b001;
        else if (w_br)                       w_n_imm[2:0] = 3'b011;
        else if (w_st)                       w_n_imm[2:0] = 3'b100;
        else if (w_opi && w_f3[1:0] == 2'b01) w_n_imm[2:0] = 3'b101;
        else if (w_jalr | w_ld | w_opi)      w_n_imm[2:0] = 3'b010;
        else                                 w_n_imm[2:0] = 3'b000;
        w_n_imm[3] = (w_ld & ((w_f3 == 3'b100) | (w_f3 == 3'b101))) | (w_opi & (w_f3 == 3'b011));
        w_n_op1 = w_auipc | w_jal | w_jalr;
        w_n_op2 = ~w_op;
        w_n_rws = {w_auipc, ~w_ld};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      CTRL_VALID       <= 1'b0;
      ILLEGAL          <= 1'b0;
      REG_FILE_WRITE   <= 1'b0;
      ALU_SIGNAL       <= '0;
      MAIN_MEM_WRITE   <= '0;
      MAIN_MEM_READ    <= '0;
      BRANCH_CONTROL   <= '0;
      IMMEDIATE_SELECT <= '0;
      OPERAND_1_SELECT <= 1'b0;
      OPERAND_2_SELECT <= 1'b0;
      REG_WRITE_SELECT <= '0;
      RD_OUT           <= '0;
    end else begin
      CTRL_VALID       <= w_n_vld;
      ILLEGAL          <= w_n_ill;
      REG_FILE_WRITE   <= w_n_rfw;
      ALU_SIGNAL       <= w_n_alu;
      MAIN_MEM_WRITE   <= w_n_mw;
      MAIN_MEM_READ    <= w_n_mr;
      BRANCH_CONTROL   <= w_n_bc;
      IMMEDIATE_SELECT <= w_n_imm;
      OPERAND_1_SELECT <= w_n_op1;
      OPERAND_2_SELECT <= w_n_op2;
      REG_WRITE_SELECT <= w_n_rws;
      RD_OUT           <= w_n_rd;
    end
  end

endmodule
